// File: rtl/vga_console_writer_m.sv
// Console byte-stream writer for the VGA text-mode frame buffer.
// Interprets CR/BS/LF/FF, prints every other byte at the cursor, and clears
// rows and the full screen with blank words using the current colours.
module vga_console_writer_m #(
  parameter logic [3:0] RST_FG = 4'h7,
  parameter logic [3:0] RST_BG = 4'h0
) (
  input  logic        i_clk_25MHz,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [7:0]  i_char,
  input  logic [3:0]  i_fg,
  input  logic [3:0]  i_bg,
  output logic        o_ready,
  output logic [3:0]  o_mem_we,
  output logic [11:0] o_mem_waddr,
  output logic [31:0] o_mem_wdata,
  output logic [6:0]  o_cursor_col,
  output logic [5:0]  o_cursor_row
);

  typedef enum logic [1:0] {
    S_CLR_SCREEN,
    S_CLR_LINE,
    S_IDLE
  } state_e;

  localparam logic [7:0]  CHAR_BS   = 8'h08;
  localparam logic [7:0]  CHAR_LF   = 8'h0A;
  localparam logic [7:0]  CHAR_FF   = 8'h0C;
  localparam logic [7:0]  CHAR_CR   = 8'h0D;
  localparam logic [7:0]  CHAR_SP   = 8'h20;
  localparam logic [6:0]  LAST_COL  = 7'd79;
  localparam logic [5:0]  LAST_ROW  = 6'd59;
  localparam logic [11:0] LINE_LAST = 12'd39;    // 40 words per row
  localparam logic [11:0] SCR_LAST  = 12'd2399;  // 60 rows * 40 words

  // First word address of a row: row*40 without a multiplier.
  function automatic logic [11:0] row_base(input logic [5:0] row);
    return ({6'd0, row} << 5) + ({6'd0, row} << 3);
  endfunction

  state_e      state_q,     state_d;
  logic [11:0] clr_cnt_q,   clr_cnt_d;
  logic [6:0]  col_q,       col_d;
  logic [5:0]  row_q,       row_d;
  logic [3:0]  fg_q,        fg_d;
  logic [3:0]  bg_q,        bg_d;
  logic [3:0]  mem_we_q,    mem_we_d;
  logic [11:0] mem_waddr_q, mem_waddr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [5:0]  next_row;
  logic [11:0] cursor_addr;
  logic [31:0] blank_word;

  // Row after the current one; the screen wraps instead of scrolling.
  assign next_row    = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;
  assign cursor_addr = row_base(row_q) + {6'd0, col_q[6:1]};
  assign blank_word  = {bg_q, fg_q, CHAR_SP, bg_q, fg_q, CHAR_SP};

  // Next-state, cursor, colour and write-port computation.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    fg_d        = fg_q;
    bg_d        = bg_q;
    mem_we_d    = 4'h0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_CLR_SCREEN: begin
        mem_we_d    = 4'hF;
        mem_waddr_d = clr_cnt_q;
        mem_wdata_d = blank_word;
        if (clr_cnt_q == SCR_LAST) begin
          clr_cnt_d = 12'd0;
          state_d   = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 12'd1;
        end
      end

      S_CLR_LINE: begin
        mem_we_d    = 4'hF;
        mem_waddr_d = row_base(row_q) + clr_cnt_q;
        mem_wdata_d = blank_word;
        if (clr_cnt_q == LINE_LAST) begin
          clr_cnt_d = 12'd0;
          state_d   = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 12'd1;
        end
      end

      S_IDLE: begin
        if (i_valid) begin
          fg_d = i_fg;
          bg_d = i_bg;
          case (i_char)
            CHAR_CR: col_d = 7'd0;
            CHAR_BS: begin
              if (col_q != 7'd0) col_d = col_q - 7'd1;
            end
            CHAR_LF: begin
              col_d     = 7'd0;
              row_d     = next_row;
              clr_cnt_d = 12'd0;
              state_d   = S_CLR_LINE;
            end
            CHAR_FF: begin
              col_d     = 7'd0;
              row_d     = 6'd0;
              clr_cnt_d = 12'd0;
              state_d   = S_CLR_SCREEN;
            end
            default: begin
              mem_waddr_d = cursor_addr;
              if (col_q[0]) begin
                mem_we_d    = 4'b1100;
                mem_wdata_d = {i_bg, i_fg, i_char, 16'h0000};
              end else begin
                mem_we_d    = 4'b0011;
                mem_wdata_d = {16'h0000, i_bg, i_fg, i_char};
              end
              if (col_q == LAST_COL) begin
                col_d     = 7'd0;
                row_d     = next_row;
                clr_cnt_d = 12'd0;
                state_d   = S_CLR_LINE;
              end else begin
                col_d = col_q + 7'd1;
              end
            end
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, cursor, colour and registered write port; reset restarts the clear.
  always_ff @(posedge i_clk_25MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_CLR_SCREEN;
      clr_cnt_q   <= 12'd0;
      col_q       <= 7'd0;
      row_q       <= 6'd0;
      fg_q        <= RST_FG;
      bg_q        <= RST_BG;
      mem_we_q    <= 4'h0;
      mem_waddr_q <= 12'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_ready      = (state_q == S_IDLE);
  assign o_mem_we     = mem_we_q;
  assign o_mem_waddr  = mem_waddr_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_cursor_col = col_q;
  assign o_cursor_row = row_q;

endmodule

// File: tb/tb_vga_console_writer_m.sv
// Self-checking bench for vga_console_writer_m. A reference model tracks the
// cursor and colours and keeps a queue of pending clear writes; every cycle
// the DUT outputs are compared with the model's expectation.
module tb_vga_console_writer_m;

  localparam logic [3:0] RST_FG = 4'h7;
  localparam logic [3:0] RST_BG = 4'h0;

  typedef struct packed {
    logic [3:0]  we;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk_25;
  logic        i_rst_n;
  logic        i_valid;
  logic [7:0]  i_char;
  logic [3:0]  i_fg;
  logic [3:0]  i_bg;
  logic        o_ready;
  logic [3:0]  o_mem_we;
  logic [11:0] o_mem_waddr;
  logic [31:0] o_mem_wdata;
  logic [6:0]  o_cursor_col;
  logic [5:0]  o_cursor_row;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int         m_col, m_row;
  logic [3:0] m_fg, m_bg;
  exp_t       pend[$];

  vga_console_writer_m #(
    .RST_FG(RST_FG),
    .RST_BG(RST_BG)
  ) dut (
    .i_clk_25MHz (clk_25),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_char      (i_char),
    .i_fg        (i_fg),
    .i_bg        (i_bg),
    .o_ready     (o_ready),
    .o_mem_we    (o_mem_we),
    .o_mem_waddr (o_mem_waddr),
    .o_mem_wdata (o_mem_wdata),
    .o_cursor_col(o_cursor_col),
    .o_cursor_row(o_cursor_row)
  );

  initial clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  function automatic logic [31:0] blank(input logic [3:0] fg, input logic [3:0] bg);
    return {bg, fg, 8'h20, bg, fg, 8'h20};
  endfunction

  task automatic model_newline();
    m_col = 0;
    m_row = (m_row == 59) ? 0 : m_row + 1;
    for (int i = 0; i < 40; i++)
      pend.push_back('{we: 4'hF, addr: 12'(m_row * 40 + i), data: blank(m_fg, m_bg)});
  endtask

  task automatic model_fill_screen();
    for (int i = 0; i < 2400; i++)
      pend.push_back('{we: 4'hF, addr: 12'(i), data: blank(m_fg, m_bg)});
  endtask

  // Effect of one accepted byte; e receives the immediate write, if any.
  task automatic model_byte(input logic [7:0] ch, input logic [3:0] fg,
                            input logic [3:0] bg, output exp_t e);
    e = '0;
    m_fg = fg;
    m_bg = bg;
    case (ch)
      8'h0D: m_col = 0;
      8'h08: if (m_col > 0) m_col = m_col - 1;
      8'h0A: model_newline();
      8'h0C: begin
        m_col = 0;
        m_row = 0;
        model_fill_screen();
      end
      default: begin
        e.addr = 12'(m_row * 40 + m_col / 2);
        if (m_col % 2 == 0) begin
          e.we   = 4'b0011;
          e.data = {16'h0000, bg, fg, ch};
        end else begin
          e.we   = 4'b1100;
          e.data = {bg, fg, ch, 16'h0000};
        end
        if (m_col == 79) model_newline();
        else m_col = m_col + 1;
      end
    endcase
  endtask

  // One clock edge: advance the model, then compare every DUT output.
  task automatic step(input string tag, output logic accepted);
    exp_t e;
    logic exp_rdy;
    accepted = i_valid && (pend.size() == 0);
    @(posedge clk_25);
    #1;
    e = '0;
    if (pend.size() != 0) e = pend.pop_front();
    else if (accepted) model_byte(i_char, i_fg, i_bg, e);
    exp_rdy = (pend.size() == 0);
    total++;
    if (o_mem_we !== e.we
        || (e.we != 4'h0 && (o_mem_waddr !== e.addr || o_mem_wdata !== e.data))
        || o_ready !== exp_rdy
        || o_cursor_col !== 7'(m_col) || o_cursor_row !== 6'(m_row)) begin
      bad++;
      $display("FAIL %s t=%0t got we=%h addr=%0d data=%h rdy=%b cur=(%0d,%0d) want we=%h addr=%0d data=%h rdy=%b cur=(%0d,%0d)",
               tag, $time, o_mem_we, o_mem_waddr, o_mem_wdata, o_ready, o_cursor_col,
               o_cursor_row, e.we, e.addr, e.data, exp_rdy, m_col, m_row);
    end
  endtask

  task automatic idle(input int n, input string tag);
    logic acc;
    i_valid = 1'b0;
    for (int i = 0; i < n; i++) step(tag, acc);
  endtask

  // Offer a byte and hold it until the model says it was accepted.
  task automatic send_byte(input logic [7:0] ch, input logic [3:0] fg,
                           input logic [3:0] bg, input string tag);
    logic acc;
    int   n;
    // NOTE: bench inputs are driven with blocking assignments, #1 after the edge.
    i_valid = 1'b1;
    i_char  = ch;
    i_fg    = fg;
    i_bg    = bg;
    acc     = 1'b0;
    n       = 0;
    while (!acc && n < 3000) begin
      step(tag, acc);
      n++;
    end
    i_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL %s accept got none in 3000 cycles want acceptance", tag);
    end
  endtask

  task automatic drain(input string tag);
    logic acc;
    int   n;
    i_valid = 1'b0;
    n = 0;
    while (pend.size() != 0 && n < 3000) begin
      step(tag, acc);
      n++;
    end
  endtask

  // Assert reset asynchronously, check outputs clear at once, then release.
  task automatic apply_reset(input string tag);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    total++;
    if (o_mem_we !== 4'h0 || o_ready !== 1'b0 || o_mem_waddr !== 12'd0
        || o_mem_wdata !== 32'd0 || o_cursor_col !== 7'd0 || o_cursor_row !== 6'd0) begin
      bad++;
      $display("FAIL %s in_reset got we=%h rdy=%b addr=%0d data=%h cur=(%0d,%0d) want all zero",
               tag, o_mem_we, o_ready, o_mem_waddr, o_mem_wdata, o_cursor_col, o_cursor_row);
    end
    pend.delete();
    m_col = 0;
    m_row = 0;
    m_fg  = RST_FG;
    m_bg  = RST_BG;
    model_fill_screen();
    @(negedge clk_25);
    @(negedge clk_25);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic acc;
    apply_reset("reset");
    for (int i = 0; i < 2400; i++) step("reset_clear", acc);
    total++;
    if (o_mem_waddr !== 12'd2399 || o_mem_wdata !== 32'h0720_0720 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_last got addr=%0d data=%h rdy=%b want addr=2399 data=07200720 rdy=1",
               o_mem_waddr, o_mem_wdata, o_ready);
    end
    step("reset_after", acc);
    total++;
    if (o_mem_we !== 4'h0 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_done got we=%h rdy=%b want we=0 rdy=1", o_mem_we, o_ready);
    end
  endtask

  task automatic test_back_to_back();
    send_byte("A", 4'hF, 4'h1, "ab_A");
    total++;
    if (o_mem_we !== 4'b0011 || o_mem_waddr !== 12'd0 || o_mem_wdata !== 32'h0000_1F41) begin
      bad++;
      $display("FAIL ab_A got we=%h addr=%0d data=%h want we=3 addr=0 data=00001f41",
               o_mem_we, o_mem_waddr, o_mem_wdata);
    end
    send_byte("B", 4'hF, 4'h1, "ab_B");
    total++;
    if (o_mem_we !== 4'b1100 || o_mem_waddr !== 12'd0 || o_mem_wdata !== 32'h1F42_0000
        || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL ab_B got we=%h addr=%0d data=%h rdy=%b want we=c addr=0 data=1f420000 rdy=1",
               o_mem_we, o_mem_waddr, o_mem_wdata, o_ready);
    end
    idle(1, "ab_idle");
    total++;
    if (o_cursor_col !== 7'd2 || o_cursor_row !== 6'd0 || o_mem_we !== 4'h0) begin
      bad++;
      $display("FAIL ab_cursor got (%0d,%0d) we=%h want (2,0) we=0",
               o_cursor_col, o_cursor_row, o_mem_we);
    end
  endtask

  task automatic test_col_wrap();
    logic acc;
    send_byte(8'h0D, 4'h7, 4'h0, "cw_cr");
    for (int i = 0; i < 3; i++) send_byte(8'h0A, 4'h7, 4'h0, "cw_lf");
    drain("cw_drain");
    for (int i = 0; i < 79; i++)
      send_byte(8'(8'h41 + $urandom_range(0, 25)), 4'($urandom), 4'($urandom), "cw_fill");
    total++;
    if (o_cursor_col !== 7'd79 || o_cursor_row !== 6'd3) begin
      bad++;
      $display("FAIL cw_pos got (%0d,%0d) want (79,3)", o_cursor_col, o_cursor_row);
    end
    send_byte("Z", 4'hE, 4'h3, "cw_Z");
    total++;
    if (o_mem_we !== 4'b1100 || o_mem_waddr !== 12'd159 || o_mem_wdata !== 32'h3E5A_0000
        || o_ready !== 1'b0 || o_cursor_col !== 7'd0 || o_cursor_row !== 6'd4) begin
      bad++;
      $display("FAIL cw_Z got we=%h addr=%0d data=%h rdy=%b cur=(%0d,%0d) want we=c addr=159 data=3e5a0000 rdy=0 cur=(0,4)",
               o_mem_we, o_mem_waddr, o_mem_wdata, o_ready, o_cursor_col, o_cursor_row);
    end
    i_valid = 1'b1;  // offered during the clear; must be ignored
    i_char  = "Q";
    for (int i = 0; i < 40; i++) begin
      acc = 1'b0;
      step("cw_clear", acc);
      if (i == 0) begin
        total++;
        if (o_mem_waddr !== 12'd160 || o_mem_wdata !== 32'h3E20_3E20) begin
          bad++;
          $display("FAIL cw_first got addr=%0d data=%h want addr=160 data=3e203e20",
                   o_mem_waddr, o_mem_wdata);
        end
      end
    end
    i_valid = 1'b0;
    total++;
    if (o_mem_waddr !== 12'd199 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL cw_last got addr=%0d rdy=%b want addr=199 rdy=1", o_mem_waddr, o_ready);
    end
  endtask

  task automatic test_row_wrap();
    for (int i = 0; i < 55; i++) send_byte(8'h0A, 4'h7, 4'h0, "rw_lf");
    drain("rw_drain");
    for (int i = 0; i < 5; i++) send_byte("a", 4'h6, 4'h2, "rw_fill");
    total++;
    if (o_cursor_col !== 7'd5 || o_cursor_row !== 6'd59) begin
      bad++;
      $display("FAIL rw_pos got (%0d,%0d) want (5,59)", o_cursor_col, o_cursor_row);
    end
    send_byte(8'h0A, 4'h7, 4'h0, "rw_lf59");
    total++;
    if (o_cursor_col !== 7'd0 || o_cursor_row !== 6'd0 || o_ready !== 1'b0) begin
      bad++;
      $display("FAIL rw_wrap got cur=(%0d,%0d) rdy=%b want cur=(0,0) rdy=0",
               o_cursor_col, o_cursor_row, o_ready);
    end
    idle(1, "rw_clear");
    total++;
    if (o_mem_we !== 4'hF || o_mem_waddr !== 12'd0) begin
      bad++;
      $display("FAIL rw_first got we=%h addr=%0d want we=f addr=0", o_mem_we, o_mem_waddr);
    end
    idle(39, "rw_clear");
    total++;
    if (o_mem_waddr !== 12'd39 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL rw_last got addr=%0d rdy=%b want addr=39 rdy=1", o_mem_waddr, o_ready);
    end
  endtask

  task automatic test_bs_cr();
    for (int i = 0; i < 7; i++) send_byte(8'h0A, 4'h7, 4'h0, "bc_lf");
    drain("bc_drain");
    send_byte(8'h08, 4'h7, 4'h0, "bc_bs0");
    total++;
    if (o_mem_we !== 4'h0 || o_cursor_col !== 7'd0 || o_cursor_row !== 6'd7) begin
      bad++;
      $display("FAIL bc_bs0 got we=%h cur=(%0d,%0d) want we=0 cur=(0,7)",
               o_mem_we, o_cursor_col, o_cursor_row);
    end
    for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i), 4'h7, 4'h0, "bc_fill");
    send_byte(8'h0D, 4'h7, 4'h0, "bc_cr");
    total++;
    if (o_mem_we !== 4'h0 || o_cursor_col !== 7'd0 || o_cursor_row !== 6'd7) begin
      bad++;
      $display("FAIL bc_cr got we=%h cur=(%0d,%0d) want we=0 cur=(0,7)",
               o_mem_we, o_cursor_col, o_cursor_row);
    end
    send_byte("x", 4'h7, 4'h0, "bc_x");
    send_byte(8'h08, 4'h7, 4'h0, "bc_bs1");
    total++;
    if (o_mem_we !== 4'h0 || o_cursor_col !== 7'd0) begin
      bad++;
      $display("FAIL bc_bs1 got we=%h col=%0d want we=0 col=0", o_mem_we, o_cursor_col);
    end
  endtask

  task automatic test_random();
    logic [7:0] ch;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       ch = 8'h0D;
        1:       ch = 8'h08;
        2:       ch = 8'h0A;
        default: begin
          ch = 8'($urandom_range(0, 255));
          if (ch == 8'h0C) ch = 8'h0B;  // full-screen clears are tested separately
        end
      endcase
      send_byte(ch, 4'($urandom), 4'($urandom), "rand");
      i_char = 8'($urandom);
      idle($urandom_range(0, 2), "rand_gap");
    end
    drain("rand_drain");
  endtask

  task automatic test_ff_abort();
    logic acc;
    send_byte(8'h0C, 4'h2, 4'h4, "ff");
    total++;
    if (o_ready !== 1'b0 || o_cursor_col !== 7'd0 || o_cursor_row !== 6'd0) begin
      bad++;
      $display("FAIL ff_accept got rdy=%b cur=(%0d,%0d) want rdy=0 cur=(0,0)",
               o_ready, o_cursor_col, o_cursor_row);
    end
    for (int i = 0; i < 1001; i++) step("ff_clear", acc);
    total++;
    if (o_mem_we !== 4'hF || o_mem_waddr !== 12'd1000 || o_mem_wdata !== 32'h4220_4220) begin
      bad++;
      $display("FAIL ff_word1000 got we=%h addr=%0d data=%h want we=f addr=1000 data=42204220",
               o_mem_we, o_mem_waddr, o_mem_wdata);
    end
    apply_reset("ff_abort");
    step("ff_restart", acc);
    total++;
    if (o_mem_waddr !== 12'd0 || o_mem_wdata !== 32'h0720_0720 || o_mem_we !== 4'hF) begin
      bad++;
      $display("FAIL ff_restart got we=%h addr=%0d data=%h want we=f addr=0 data=07200720",
               o_mem_we, o_mem_waddr, o_mem_wdata);
    end
    drain("ff_reclear");
    idle(2, "ff_tail");
  endtask

  initial begin
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_char  = 8'h00;
    i_fg    = 4'h0;
    i_bg    = 4'h0;
    #5;
    test_reset();
    test_back_to_back();
    test_col_wrap();
    test_row_wrap();
    test_bs_cr();
    test_random();
    test_ff_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
